// File: rtl/conway_seed_controller.sv
// conway_seed_controller: loads a seed board row-by-row, then paces generations of a conway_cell grid.
// Ports: clk/rst (sync, active-high); load, run, step control levels;
// seed_data/seed_valid/seed_ready row stream; state_0 seed vector (row r at [r*N +: N]);
// board_rst/board_ena drive the cells; generation counts pulses since last seed; busy in LOAD/APPLY.
module conway_seed_controller #(
    parameter int N        = 8,
    parameter int M        = 8,
    parameter int TICK_DIV = 1000000,
    parameter int GEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N-1:0]     seed_data,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic             run,
    input  logic             step,
    output logic [N*M-1:0]   state_0,
    output logic             board_rst,
    output logic             board_ena,
    output logic [GEN_W-1:0] generation,
    output logic             busy
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    typedef enum logic [1:0] {LOAD, APPLY, PAUSED, RUNNING} state_t;
    state_t           state, state_n;
    logic [RW-1:0]    row, row_n;
    logic [TW-1:0]    tick, tick_n;
    logic             apply_cnt, apply_cnt_n;
    logic             step_q;
    logic [N*M-1:0]   state_0_n;
    logic [GEN_W-1:0] generation_n;
    logic             ena_n;
    logic             last_row;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            row        <= '0;
            tick       <= '0;
            apply_cnt  <= 1'b0;
            step_q     <= 1'b0;
            state_0    <= '0;
            generation <= '0;
            board_rst  <= 1'b1;
            board_ena  <= 1'b0;
            seed_ready <= 1'b1;
            busy       <= 1'b1;
        end else begin
            state      <= state_n;
            row        <= row_n;
            tick       <= tick_n;
            apply_cnt  <= apply_cnt_n;
            step_q     <= step;
            state_0    <= state_0_n;
            generation <= generation_n;
            board_rst  <= state_n == LOAD || state_n == APPLY;
            board_ena  <= ena_n;
            seed_ready <= state_n == LOAD;
            busy       <= state_n == LOAD || state_n == APPLY;
        end
    end
    // ena_n is a registered pulse: it is computed for the cycle in which the
    // tick counter will sit at its terminal count, so the pulse and the count align.
    always_comb begin
        state_n      = state;
        row_n        = row;
        tick_n       = tick;
        apply_cnt_n  = apply_cnt;
        state_0_n    = state_0;
        generation_n = generation;
        ena_n        = 1'b0;
        last_row     = row == RW'(M - 1);
        case (state)
            LOAD: if (seed_valid && seed_ready) begin
                state_0_n[row*N +: N] = seed_data;
                row_n       = last_row ? '0 : row + RW'(1);
                state_n     = last_row ? APPLY : LOAD;
                apply_cnt_n = 1'b0;
            end
            APPLY: begin
                apply_cnt_n = 1'b1;
                state_n     = apply_cnt ? PAUSED : APPLY;
            end
            PAUSED: if (load) begin
                state_n      = LOAD;
                generation_n = '0;
            end else if (run) begin
                state_n = RUNNING;
                tick_n  = '0;
                ena_n   = tick_n == TW'(TICK_DIV - 1);
            end else begin
                ena_n = step & ~step_q;
            end
            RUNNING: if (load) begin
                state_n      = LOAD;
                generation_n = '0;
            end else if (!run) begin
                state_n = PAUSED;
                tick_n  = '0;
            end else begin
                tick_n = (tick == TW'(TICK_DIV - 1)) ? '0 : tick + TW'(1);
                ena_n  = tick_n == TW'(TICK_DIV - 1);
            end
            default: state_n = LOAD;
        endcase
        generation_n = ena_n ? generation + GEN_W'(1) : generation_n;
    end
endmodule

// File: doc/conway_seed_controller.md
# conway_seed_controller

- Upstream control stage for a grid of `conway_cell` instances.
- Loads an initial board pattern row-by-row over a valid/ready stream and drives it onto the cells' `state_0` inputs while holding the board in reset.
- Releases reset, then paces generations by pulsing the board's `ena`: free-running at a programmable rate, or single-stepped.
- Maintains a generation counter for display/debug.

## Interface
- `N`, 8: board width, cells per row.
- `M`, 8: board height, number of rows.
- `TICK_DIV`, 1000000: clock cycles per generation in run mode; must be ≥1.
- `GEN_W`, 16: generation counter width.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: level; start a new seed load, sampled in PAUSED/RUNNING.
- `seed_data` in N: one board row; bit c = column c.
- `seed_valid` in 1: `seed_data` valid.
- `seed_ready` out 1: controller accepts a row this cycle.
- `run` in 1: level; free-run generations while high.
- `step` in 1: rising edge requests one generation while paused.
- `state_0` out N*M: seed vector to cells; row r occupies `[r*N +: N]`.
- `board_rst` out 1: drives cell `rst`.
- `board_ena` out 1: drives cell `ena`; one-cycle pulse per generation.
- `generation` out GEN_W: generations advanced since last seed.
- `busy` out 1: high in LOAD or APPLY.

## Operation
States: LOAD, APPLY, PAUSED, RUNNING.

- **Reset.** Outputs and state after reset:
  - state = LOAD, row index = 0.
  - `state_0` = 0, `generation` = 0.
  - `board_rst` = 1, `board_ena` = 0, `seed_ready` = 1, `busy` = 1.
  - Tick counter = 0, step edge register = 0.
- **LOAD.**
  - `seed_ready` = 1, `board_rst` = 1.
  - On `seed_valid & seed_ready`: write `seed_data` to row r and increment r.
  - Accepting row M-1 moves to APPLY; r returns to 0.
  - Rows not yet written in this load keep their previous values.
  - `run`, `step` and `load` are ignored.
- **APPLY.**
  - `seed_ready` = 0, `board_rst` held 1 for exactly 2 cycles so the cells capture `state_0`.
  - Then go to PAUSED.
- **PAUSED.**
  - `board_rst` = 0.
  - `load` = 1: go to LOAD, clear `generation`.
  - Else `run` = 1: go to RUNNING, tick counter = 0.
  - Else a step rising edge (`step & ~step_q`, with `step_q` registered every cycle in all states): one `board_ena` pulse and `generation`+1.
  - Priority: `load` > `run` > `step`.
- **RUNNING.**
  - Tick counter counts 0..TICK_DIV-1 and wraps.
  - At terminal count: `board_ena` pulse and `generation`+1.
  - `load` = 1: go to LOAD, clear `generation`.
  - Else `run` = 0: go to PAUSED, tick counter = 0; no pulse issued that cycle.
  - `step` is ignored.
- **Arithmetic.** `generation` wraps modulo 2^GEN_W (all-ones + 1 = 0). The tick counter is `$clog2(TICK_DIV+1)` bits.
- **Outputs.** `board_ena` is never high while `board_rst` is high. `seed_valid` outside LOAD is dropped: no write, no ready.

## Timing
- All outputs are registered; no combinational input→output paths.
- **Row write:** handshake at edge k ⇒ `state_0` shows the row from cycle k+1.
- **Load to pause:** last row accepted at edge k.
  - APPLY occupies cycles k+1 and k+2.
  - `board_rst` falls and PAUSED begins at k+3.
- **Step:** rising edge sampled at edge k ⇒ `board_ena` = 1 for cycle k+1 only; `generation` updates at the same edge. Holding `step` high yields only one pulse.
- **Run:**
  - Entry edge k ⇒ first `board_ena` pulse in cycle k+TICK_DIV.
  - Subsequent pulses every TICK_DIV cycles.
  - TICK_DIV = 1 ⇒ `board_ena` high every RUNNING cycle.
- **`load` mid-run:** any `board_ena` pulse already registered completes; `seed_ready` rises the cycle after `load` is sampled.
- **`rst` mid-operation** (any state, incl. mid-LOAD): next cycle equals the reset state; partial seed is discarded.

## Test plan
- **Reset/seed load.** N=M=4; feed rows 4'b0010, 4'b0100, 4'b0111, 4'b0000 with `seed_valid` held high ⇒
  - `seed_ready` high 4 cycles.
  - `state_0` = 16'h0742.
  - `board_rst` high through 2 APPLY cycles, then 0.
  - `busy` falls with it; `generation` = 0.
- **Backpressure gaps.** Toggle `seed_valid` 1,0,0,1,... ⇒ rows written only on valid cycles; the APPLY entry edge follows the 4th accepted row exactly.
- **Single step.** In PAUSED, hold `step` high 5 cycles ⇒
  - Exactly one 1-cycle `board_ena`, `generation` = 1.
  - Re-pulse `step` ⇒ `generation` = 2.
- **Free run.** TICK_DIV = 3, `run` high 10 cycles ⇒ `board_ena` pulses at cycles 3, 6, 9 after entry; `generation` = 3. Drop `run` ⇒ no further pulses.
- **Priority/abort.**
  - `run` and `step` rise together in PAUSED ⇒ RUNNING, no step pulse.
  - `load` asserted in RUNNING ⇒ LOAD next cycle, `generation` = 0, `board_rst` = 1, tick counter restarted on next run.
- **Wrap/reset.**
  - GEN_W = 2, five steps ⇒ `generation` sequence 1, 2, 3, 0, 1.
  - `rst` after 2 of 4 rows ⇒ `state_0` = 0, row index 0, next accepted row lands in row 0.
